// File: rtl/mips_pkg.sv
// Shared MEM-stage types: access size encodings, LSU state and a
// misalignment helper used by the load/store unit.
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    // Size 2'b11 is handled exactly like a word access.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic half_bad;
        logic word_bad;
        half_bad = (size == SZ_HALF) && lo[0];
        word_bad = size[1] && (lo != 2'b00);
        return half_bad || word_bad;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-bus bundle between the LSU (master) and the data memory
// or interconnect (slave): req/ack handshake plus payload.
interface mem_stage_lsu_if;

    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req,
        output dbus_we,
        output dbus_addr,
        output dbus_be,
        output dbus_wdata,
        input  dbus_ack,
        input  dbus_rdata
    );

    modport slave (
        input  dbus_req,
        input  dbus_we,
        input  dbus_addr,
        input  dbus_be,
        input  dbus_wdata,
        output dbus_ack,
        output dbus_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte enables / replicated data,
// and little-endian load lane select with sign or zero extension.
module lsu_align
    import mips_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_raw[7:0];
        case (ld_lo)
            2'd0:    ld_byte = ld_raw[7:0];
            2'd1:    ld_byte = ld_raw[15:8];
            2'd2:    ld_byte = ld_raw[23:16];
            default: ld_byte = ld_raw[31:24];
        endcase
        ld_half = ld_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    end

    always_comb begin
        ld_data = ld_raw;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: IDLE/BUSY/DONE handshake FSM on the data bus.
// Define LSU_TIMEOUT_EN to abort bus waits after TIMEOUT_CYCLES cycles.
module mem_stage_lsu
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mem_valid,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [1:0]         mem_size,
    input  logic               mem_unsigned,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               lsu_stall,
    output logic               misalign,
    output logic               bus_err,
    mem_stage_lsu_if.master    dbus
);

    lsu_state_e  state_q, state_d;
    logic        access, mis, start;
    logic        launch, finish, timeout, tmo_hit;
    logic        req_q, we_q, rd_q, uns_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [1:0]  size_q, lo_q;
    logic [3:0]  be_w;
    logic [31:0] wdata_w, ld_ext;

    assign access = mem_valid & (mem_read | mem_write);
    assign mis    = is_misaligned(mem_size, mem_addr[1:0]);
    assign start  = access & ~mis;

    lsu_align u_align (
        .st_size     (mem_size),
        .st_lo       (mem_addr[1:0]),
        .st_data     (mem_wdata),
        .st_be       (be_w),
        .st_wdata    (wdata_w),
        .ld_size     (size_q),
        .ld_lo       (lo_q),
        .ld_unsigned (uns_q),
        .ld_raw      (dbus.dbus_rdata),
        .ld_data     (ld_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        lsu_stall = 1'b0;
        misalign  = 1'b0;
        launch    = 1'b0;
        finish    = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    lsu_stall = 1'b1;
                    state_d   = BUSY;
                end else if (access) begin
                    misalign  = 1'b1;
                end
            end
            BUSY: begin
                lsu_stall = 1'b1;
                if (dbus.dbus_ack) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (launch) begin
                req_q   <= 1'b1;
                we_q    <= mem_write;
                rd_q    <= mem_read;
                uns_q   <= mem_unsigned;
                addr_q  <= {mem_addr[31:2], 2'b00};
                be_q    <= be_w;
                wdata_q <= wdata_w;
                size_q  <= mem_size;
                lo_q    <= mem_addr[1:0];
            end
            if (finish) begin
                req_q   <= 1'b0;
                rdata_q <= rd_q ? ld_ext : 32'h0;
            end
            if (timeout) begin
                req_q   <= 1'b0;
                rdata_q <= 32'h0;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign bus_err = err_q & (state_q == DONE);

    // Counter restarts with every launched access.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (launch)
                cnt_q <= '0;
            else if (state_q == BUSY && !dbus.dbus_ack)
                cnt_q <= cnt_q + 1'b1;
            if (launch)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo_hit    = 1'b0;
    assign bus_err    = 1'b0;
`endif

    assign mem_rdata       = (state_q == DONE) ? rdata_q : 32'h0;
    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_be    = be_q;
    assign dbus.dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a behavioural access model.
// Build with LSU_TIMEOUT_EN to also exercise the bus-wait abort.
module tb_mem_stage_lsu;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        lsu_stall, misalign, bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_lsu_if dbus ();

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_valid    (mem_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .lsu_stall    (lsu_stall),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .dbus         (dbus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_mis(input logic [1:0] sz, input logic [31:0] a);
        int lo = int'(a[1:0]);
        if (sz == 2'd1) return (lo % 2) != 0;
        if (sz >= 2'd2) return lo != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] mdl_be(input logic [1:0] sz,
                                          input logic [31:0] a);
        int lo = int'(a[1:0]);
        if (sz == 2'd0) return 4'(1 << lo);
        if (sz == 2'd1) return (lo >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] mdl_wd(input logic [1:0] sz,
                                           input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] mdl_ld(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a,
                                           input logic [31:0] raw);
        logic [31:0] v;
        int sh = 8 * int'(a[1:0]);
        if (sz == 2'd0) begin
            v = (raw >> sh) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
            return v;
        end
        if (sz == 2'd1) begin
            v = (raw >> sh) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
            return v;
        end
        return raw;
    endfunction

    task automatic idle_inputs();
        mem_valid    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_unsigned = 1'b0;
        mem_size     = 2'd0;
    endtask

    // Called at a negedge with the LSU in IDLE; ack arrives in BUSY cycle k.
    task automatic run_access(input string tag, input bit rd,
                              input logic [1:0] sz, input bit uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] raw, input int k);
        int stalls = 0;
        mem_valid    = 1'b1;
        mem_read     = rd;
        mem_write    = !rd;
        mem_size     = sz;
        mem_unsigned = uns;
        mem_addr     = a;
        mem_wdata    = wd;
        #1;
        if (mdl_mis(sz, a)) begin
            check({tag, ".mis"}, 32'(misalign), 32'd1);
            check({tag, ".mis_stall"}, 32'(lsu_stall), 32'd0);
            @(negedge clk);
            idle_inputs();
            #1;
            check({tag, ".mis_req"}, 32'(dbus.dbus_req), 32'd0);
            return;
        end
        check({tag, ".idle_stall"}, 32'(lsu_stall), 32'd1);
        check({tag, ".idle_req"}, 32'(dbus.dbus_req), 32'd0);
        stalls += int'(lsu_stall);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            if (i == k) begin
                dbus.dbus_ack   = 1'b1;
                dbus.dbus_rdata = raw;
            end
            #1;
            stalls += int'(lsu_stall);
            check({tag, ".req"}, 32'(dbus.dbus_req), 32'd1);
            check({tag, ".we"}, 32'(dbus.dbus_we), 32'(!rd));
            check({tag, ".addr"}, dbus.dbus_addr, a & 32'hFFFFFFFC);
            check({tag, ".be"}, 32'(dbus.dbus_be), 32'(mdl_be(sz, a)));
            if (!rd)
                check({tag, ".wdata"}, dbus.dbus_wdata, mdl_wd(sz, wd));
        end
        @(negedge clk);
        dbus.dbus_ack   = 1'b0;
        dbus.dbus_rdata = $urandom;
        #1;
        check({tag, ".done_stall"}, 32'(lsu_stall), 32'd0);
        check({tag, ".done_req"}, 32'(dbus.dbus_req), 32'd0);
        check({tag, ".done_err"}, 32'(bus_err), 32'd0);
        check({tag, ".stalls"}, 32'(stalls), 32'(k + 1));
        if (rd)
            check({tag, ".rdata"}, mem_rdata, mdl_ld(sz, uns, a, raw));
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        reset_n         = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        dbus.dbus_ack   = 1'b0;
        dbus.dbus_rdata = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("rst.req", 32'(dbus.dbus_req), 32'd0);
        check("rst.stall", 32'(lsu_stall), 32'd0);
        check("rst.rdata", mem_rdata, 32'd0);
        check("rst.mis", 32'(misalign), 32'd0);
        check("rst.err", 32'(bus_err), 32'd0);
        check("rst.addr", dbus.dbus_addr, 32'd0);
        check("rst.be", 32'(dbus.dbus_be), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_access("sw", 0, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 3);
        run_access("sb", 0, 2'd0, 0, 32'h203, 32'h12345678, 32'h0, 1);
        run_access("lb", 1, 2'd0, 0, 32'h201, 32'h0, 32'h000080FF, 1);
        run_access("lbu", 1, 2'd0, 1, 32'h201, 32'h0, 32'h000080FF, 2);
        run_access("lh", 1, 2'd1, 0, 32'h102, 32'h0, 32'h80010000, 1);
        run_access("lw_mis", 1, 2'd2, 0, 32'h102, 32'h0, 32'h0, 1);

        mem_valid = 1'b1;
        mem_addr  = 32'h44;
        #1;
        check("nop.stall", 32'(lsu_stall), 32'd0);
        check("nop.mis", 32'(misalign), 32'd0);
        check("nop.rdata", mem_rdata, 32'd0);
        @(negedge clk);
        idle_inputs();

        mem_valid = 1'b1;
        mem_read  = 1'b1;
        mem_size  = 2'd2;
        mem_addr  = 32'h300;
        @(negedge clk);
        check("rstb.req", 32'(dbus.dbus_req), 32'd1);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rstb.req_drop", 32'(dbus.dbus_req), 32'd0);
        reset_n         = 1'b1;
        dbus.dbus_ack   = 1'b1;
        dbus.dbus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dbus.dbus_ack = 1'b0;
        #1;
        check("late_ack.req", 32'(dbus.dbus_req), 32'd0);
        check("late_ack.stall", 32'(lsu_stall), 32'd0);
        check("late_ack.rdata", mem_rdata, 32'd0);
        run_access("lw_after", 1, 2'd2, 0, 32'h304, 32'h0, 32'h13579BDF, 2);

`ifdef LSU_TIMEOUT_EN
        mem_valid = 1'b1;
        mem_read  = 1'b1;
        mem_size  = 2'd2;
        mem_addr  = 32'h400;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk);
            #1;
            check("tmo.busy_req", 32'(dbus.dbus_req), 32'd1);
        end
        @(negedge clk);
        #1;
        check("tmo.err", 32'(bus_err), 32'd1);
        check("tmo.rdata", mem_rdata, 32'd0);
        check("tmo.stall", 32'(lsu_stall), 32'd0);
        check("tmo.req", 32'(dbus.dbus_req), 32'd0);
        idle_inputs();
        @(negedge clk);
        #1;
        check("tmo.err_clear", 32'(bus_err), 32'd0);
        @(negedge clk);
`endif

        for (int t = 0; t < 200; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom & 32'h0000FFFF;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz[1]) a[1:0] = 2'b00;
            end
            run_access("rnd", 1'($urandom_range(0, 1)), sz,
                       1'($urandom_range(0, 1)), a, $urandom, $urandom,
                       $urandom_range(1, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
